// File: rtl/fifo_fill_pkg.sv
// Shared definitions for the FIFO fill (write-side) and drain (read-side) controllers.
// Contents:
//   fill_state_e     - controller FSM state encoding (idle, request, transfer)
//   BurstLenDefault  - default words per memory burst
//   ThreshDefault    - default FIFO fill level below which a new burst may start
package fifo_fill_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StReq   = 2'd1,
    StXfer  = 2'd2
  } fill_state_e;

  localparam int unsigned BurstLenDefault = 8;
  localparam int unsigned ThreshDefault   = 256;

endpackage

// File: rtl/fifo_fill_ctrl.sv
// FIFO fill controller: fetches a frame from memory in fixed-length bursts and
// pushes the returned words into a downstream FIFO, throttled by its fill level.
// Ports:
//   wrclk        - clock
//   aclr         - synchronous active-low reset
//   frame_start  - pulse: restart fetching from base_addr / frame_words
//   base_addr    - frame start word address (sampled on restart)
//   frame_words  - 16-bit words in the frame (sampled on restart)
//   mem_req      - burst request, held until mem_ack
//   mem_addr     - burst start address
//   mem_ack      - request accepted
//   mem_dvalid   - read beat strobe
//   mem_data     - read beat data
//   fifo_data    - FIFO write data (one cycle after the beat)
//   fifo_wrreq   - FIFO write strobe
//   fifo_wrusedw - FIFO write-side fill level
//   busy         - high while a burst is requested or in flight
module fifo_fill_ctrl
  import fifo_fill_pkg::*;
#(
  parameter int unsigned BURST_LEN = BurstLenDefault,
  parameter int unsigned THRESH    = ThreshDefault,
  parameter int unsigned AW        = 20
) (
  input  logic          wrclk,
  input  logic          aclr,
  input  logic          frame_start,
  input  logic [AW-1:0] base_addr,
  input  logic [19:0]   frame_words,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic          mem_dvalid,
  input  logic [15:0]   mem_data,
  output logic [15:0]   fifo_data,
  output logic          fifo_wrreq,
  input  logic [8:0]    fifo_wrusedw,
  output logic          busy
);

  localparam int unsigned BeatW  = $clog2(BURST_LEN) + 1;
  localparam int unsigned WordsW = 20;

  fill_state_e       state_q;
  logic [AW-1:0]     cur_addr_q;
  logic [WordsW-1:0] remaining_q;
  logic [BeatW-1:0]  beat_q;
  logic              pending_q;
  // Blocks the first idle cycle after a deferred reload.
  logic              hold_q;
  // Registered fill-level compare; only consulted in idle.
  logic              thresh_ok_q;

  logic              restart;
  logic              last_beat;
  logic              beat_wr;
  logic [WordsW-1:0] next_remaining;

  always_comb begin
    restart        = pending_q | frame_start;
    last_beat      = mem_dvalid && (beat_q == BeatW'(BURST_LEN - 1));
    // Beats past the end of the frame are consumed but not written.
    beat_wr        = WordsW'(beat_q) < remaining_q;
    next_remaining = (remaining_q > WordsW'(BURST_LEN)) ? remaining_q - WordsW'(BURST_LEN) : '0;
  end

  assign busy = (state_q != StIdle);

  always_ff @(posedge wrclk) begin
    if (!aclr) begin
      state_q     <= StIdle;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      fifo_wrreq  <= 1'b0;
      fifo_data   <= '0;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      beat_q      <= '0;
      pending_q   <= 1'b0;
      hold_q      <= 1'b0;
      thresh_ok_q <= 1'b0;
    end else begin
      fifo_wrreq  <= 1'b0;
      thresh_ok_q <= (32'(fifo_wrusedw) < THRESH);
      unique case (state_q)
        StIdle: begin
          if (frame_start) begin
            cur_addr_q  <= base_addr;
            remaining_q <= frame_words;
            hold_q      <= 1'b0;
          end else if (hold_q) begin
            hold_q <= 1'b0;
          end else if ((remaining_q != '0) && thresh_ok_q) begin
            state_q  <= StReq;
            mem_req  <= 1'b1;
            mem_addr <= cur_addr_q;
          end
        end
        StReq: begin
          if (frame_start) pending_q <= 1'b1;
          if (mem_ack) begin
            mem_req <= 1'b0;
            beat_q  <= '0;
            state_q <= StXfer;
          end
        end
        StXfer: begin
          if (frame_start) pending_q <= 1'b1;
          if (mem_dvalid) begin
            beat_q <= beat_q + BeatW'(1);
            if (beat_wr) begin
              fifo_wrreq <= 1'b1;
              fifo_data  <= mem_data;
            end
            if (last_beat) begin
              state_q <= StIdle;
              // A restart seen during the burst (or on its last beat) replaces
              // the normal advance.
              if (restart) begin
                cur_addr_q  <= base_addr;
                remaining_q <= frame_words;
                pending_q   <= 1'b0;
                hold_q      <= 1'b1;
              end else begin
                cur_addr_q  <= cur_addr_q + AW'(BURST_LEN);
                remaining_q <= next_remaining;
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_fill_ctrl.sv
// Self-checking bench for fifo_fill_ctrl: directed frames against a queue model of
// expected burst addresses and FIFO writes, plus literal expectations per scenario.
module tb_fifo_fill_ctrl;

  logic        wrclk;
  logic        aclr;
  logic        frame_start;
  logic [19:0] base_addr;
  logic [19:0] frame_words;
  logic        mem_req;
  logic [19:0] mem_addr;
  logic        mem_ack;
  logic        mem_dvalid;
  logic [15:0] mem_data;
  logic [15:0] fifo_data;
  logic        fifo_wrreq;
  logic [8:0]  fifo_wrusedw;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int nwrites = 0;

  logic [19:0] exp_addr[$];
  logic [15:0] exp_data[$];
  logic [19:0] acc_addrs[$];

  fifo_fill_ctrl #(
    .BURST_LEN(8),
    .THRESH   (256),
    .AW       (20)
  ) dut (
    .wrclk       (wrclk),
    .aclr        (aclr),
    .frame_start (frame_start),
    .base_addr   (base_addr),
    .frame_words (frame_words),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_dvalid  (mem_dvalid),
    .mem_data    (mem_data),
    .fifo_data   (fifo_data),
    .fifo_wrreq  (fifo_wrreq),
    .fifo_wrusedw(fifo_wrusedw),
    .busy        (busy)
  );

  initial begin
    wrclk = 1'b0;
    forever #5 wrclk = ~wrclk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [15:0] data_of(input logic [19:0] a);
    return a[15:0] ^ {a[19:16], 12'h5A3};
  endfunction

  task automatic chk(input bit ok, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one burst fetched from a, of which the first n words reach the FIFO.
  function automatic void push_burst(input logic [19:0] a, input int n);
    exp_addr.push_back(a);
    for (int i = 0; i < n; i++) exp_data.push_back(data_of(a + 20'(i)));
  endfunction

  // Model: whole frame in 8-word bursts with a truncated tail, addresses wrapping.
  function automatic void push_frame(input logic [19:0] base, input int words);
    logic [19:0] a;
    int rem;
    int n;
    a   = base;
    rem = words;
    while (rem > 0) begin
      n = (rem < 8) ? rem : 8;
      push_burst(a, n);
      a   = a + 20'd8;
      rem = rem - n;
    end
  endfunction

  // Compare process: request handshake, write latency/data, busy.
  initial begin
    logic        prev_req;
    logic [19:0] prev_addr;
    logic [19:0] ea;
    logic [15:0] ed;
    prev_req  = 1'b0;
    prev_addr = '0;
    forever begin
      @(posedge wrclk);
      #1;
      if (!aclr) begin
        chk(!mem_req && mem_addr == '0 && !fifo_wrreq && fifo_data == '0 && !busy,
            "reset_outputs", {mem_req, fifo_wrreq, busy, 9'd0, mem_addr}, 32'd0);
      end else begin
        if (prev_req) begin
          if (mem_ack) begin
            ea = (exp_addr.size() > 0) ? exp_addr.pop_front() : 20'hxxxxx;
            chk(ea === prev_addr, "req_addr", prev_addr, ea);
            acc_addrs.push_back(prev_addr);
            chk(!mem_req, "req_drop_after_ack", mem_req, 0);
          end else begin
            chk(mem_req && mem_addr == prev_addr, "req_hold_stable", mem_addr, prev_addr);
          end
        end
        if (fifo_wrreq) begin
          nwrites++;
          chk(mem_dvalid && fifo_data == mem_data, "write_latency", fifo_data, mem_data);
          ed = (exp_data.size() > 0) ? exp_data.pop_front() : 16'hxxxx;
          chk(ed === fifo_data, "write_data", fifo_data, ed);
        end
        if (mem_req) chk(busy, "busy_during_req", busy, 1);
      end
      prev_req  = mem_req;
      prev_addr = mem_addr;
    end
  end

  task automatic sample();
    @(posedge wrclk);
    #1;
  endtask

  task automatic pulse_start(input logic [19:0] base, input logic [19:0] words);
    @(negedge wrclk);
    base_addr   = base;
    frame_words = words;
    frame_start = 1'b1;
    @(negedge wrclk);
    frame_start = 1'b0;
  endtask

  // Wait (bounded) for a request, then ack it two cycles later.
  task automatic req_handshake(output logic [19:0] a, output bit ok);
    int t;
    t = 0;
    while (!mem_req && t < 50) begin
      @(negedge wrclk);
      t++;
    end
    ok = mem_req;
    chk(ok, "req_timeout", mem_req, 1);
    a = mem_addr;
    if (ok) begin
      @(negedge wrclk);
      mem_ack = 1'b1;
      @(negedge wrclk);
      mem_ack = 1'b0;
    end
  endtask

  task automatic serve_burst(input int rs1, input int rs2, input bit raise);
    logic [19:0] a;
    bit ok;
    req_handshake(a, ok);
    if (ok) begin
      if (raise) fifo_wrusedw = 9'd300;
      for (int i = 0; i < 8; i++) begin
        mem_dvalid  = 1'b1;
        mem_data    = data_of(a + 20'(i));
        frame_start = (i == rs1) || (i == rs2);
        @(negedge wrclk);
      end
      mem_dvalid  = 1'b0;
      frame_start = 1'b0;
    end
  endtask

  task automatic end_checks(input string name);
    repeat (6) @(negedge wrclk);
    chk(exp_addr.size() == 0, {name, "_reqs_done"}, exp_addr.size(), 0);
    chk(exp_data.size() == 0, {name, "_writes_done"}, exp_data.size(), 0);
    chk(!busy && !mem_req, {name, "_idle"}, {busy, mem_req}, 0);
    exp_addr.delete();
    exp_data.delete();
  endtask

  task automatic new_scenario();
    acc_addrs.delete();
    nwrites = 0;
  endtask

  initial begin
    logic [19:0] a;
    bit ok;
    aclr         = 1'b0;
    frame_start  = 1'b0;
    base_addr    = '0;
    frame_words  = '0;
    mem_ack      = 1'b0;
    mem_dvalid   = 1'b0;
    mem_data     = '0;
    fifo_wrusedw = '0;
    repeat (3) @(negedge wrclk);
    aclr = 1'b1;

    // No request before the first frame_start.
    repeat (5) begin
      sample();
      chk(!mem_req && !busy, "no_req_before_start", {mem_req, busy}, 0);
    end

    // Basic fill: 32 words from 0x00100.
    new_scenario();
    push_frame(20'h00100, 32);
    pulse_start(20'h00100, 20'd32);
    repeat (4) serve_burst(-1, -1, 1'b0);
    end_checks("basic");
    chk(acc_addrs.size() == 4, "basic_req_count", acc_addrs.size(), 4);
    if (acc_addrs.size() == 4) begin
      chk(acc_addrs[0] == 20'h00100, "basic_addr0", acc_addrs[0], 20'h00100);
      chk(acc_addrs[1] == 20'h00108, "basic_addr1", acc_addrs[1], 20'h00108);
      chk(acc_addrs[2] == 20'h00110, "basic_addr2", acc_addrs[2], 20'h00110);
      chk(acc_addrs[3] == 20'h00118, "basic_addr3", acc_addrs[3], 20'h00118);
    end
    chk(nwrites == 32, "basic_write_count", nwrites, 32);

    // Throttle: full FIFO holds off the request; 255 releases it two cycles later.
    new_scenario();
    fifo_wrusedw = 9'd256;
    push_frame(20'h00200, 8);
    pulse_start(20'h00200, 20'd8);
    repeat (10) begin
      sample();
      chk(!mem_req, "throttle_hold", mem_req, 0);
    end
    @(negedge wrclk);
    fifo_wrusedw = 9'd255;
    sample();
    chk(!mem_req, "throttle_edge1", mem_req, 0);
    sample();
    chk(mem_req, "throttle_edge2", mem_req, 1);
    serve_burst(-1, -1, 1'b0);
    fifo_wrusedw = '0;
    end_checks("throttle");
    chk(nwrites == 8, "throttle_write_count", nwrites, 8);

    // Truncation (13 words), with the fill level rising mid-burst.
    new_scenario();
    push_frame(20'h00700, 13);
    pulse_start(20'h00700, 20'd13);
    serve_burst(-1, -1, 1'b1);
    repeat (8) begin
      sample();
      chk(!mem_req, "full_after_burst", mem_req, 0);
    end
    chk(nwrites == 8, "burst_not_aborted", nwrites, 8);
    @(negedge wrclk);
    fifo_wrusedw = '0;
    serve_burst(-1, -1, 1'b0);
    end_checks("trunc");
    chk(nwrites == 13, "trunc_write_count", nwrites, 13);
    chk(acc_addrs.size() == 2, "trunc_req_count", acc_addrs.size(), 2);

    // Address wrap.
    new_scenario();
    push_frame(20'hFFFF8, 16);
    pulse_start(20'hFFFF8, 20'd16);
    repeat (2) serve_burst(-1, -1, 1'b0);
    end_checks("wrap");
    if (acc_addrs.size() == 2) chk(acc_addrs[1] == 20'h00000, "wrap_addr1", acc_addrs[1], 0);
    else chk(1'b0, "wrap_req_count", acc_addrs.size(), 2);

    // Mid-burst restart, second pulse on the final beat collapses into the same reload.
    new_scenario();
    push_burst(20'h00300, 8);
    push_frame(20'h40000, 16);
    pulse_start(20'h00300, 20'd32);
    base_addr   = 20'h40000;
    frame_words = 20'd16;
    serve_burst(3, 7, 1'b0);
    repeat (2) serve_burst(-1, -1, 1'b0);
    end_checks("restart");
    chk(nwrites == 24, "restart_write_count", nwrites, 24);
    if (acc_addrs.size() == 3) chk(acc_addrs[1] == 20'h40000, "restart_addr", acc_addrs[1],
                                   20'h40000);
    else chk(1'b0, "restart_req_count", acc_addrs.size(), 3);

    // Reset mid-transfer after beat 2, then stray beats.
    new_scenario();
    push_burst(20'h00500, 3);
    pulse_start(20'h00500, 20'd16);
    req_handshake(a, ok);
    for (int i = 0; i < 3; i++) begin
      mem_dvalid = 1'b1;
      mem_data   = data_of(a + 20'(i));
      @(negedge wrclk);
    end
    aclr       = 1'b0;
    mem_dvalid = 1'b0;
    @(negedge wrclk);
    aclr = 1'b1;
    for (int i = 3; i < 8; i++) begin
      mem_dvalid = 1'b1;
      mem_data   = data_of(a + 20'(i));
      @(negedge wrclk);
    end
    mem_dvalid = 1'b0;
    repeat (10) begin
      sample();
      chk(!mem_req && !busy, "no_req_after_reset", {mem_req, busy}, 0);
    end
    chk(nwrites == 3, "reset_write_count", nwrites, 3);
    chk(mem_addr == '0 && fifo_data == '0, "reset_cleared", {fifo_data, mem_addr[15:0]}, 0);
    end_checks("reset");

    // Recovery after reset.
    new_scenario();
    push_frame(20'h00600, 8);
    pulse_start(20'h00600, 20'd8);
    serve_burst(-1, -1, 1'b0);
    end_checks("recover");
    chk(nwrites == 8, "recover_write_count", nwrites, 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
